// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, loads the start PC from the
// reset vector in words 0/1, then streams 16-bit words to the IF/ID register,
// marking the immediate word of a 32-bit instruction as a bubble.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned IMM_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic [15:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       instruction,
  output logic [31:0]       pc,
  output logic [31:0]       nextPC,
  output logic              iamBubble,
  output logic              flush
);

  localparam logic [1:0] VEC_HI = 2'd0;
  localparam logic [1:0] VEC_LO = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] IMM    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        has_imm;
  logic        running;

  assign has_imm = imem_data[IMM_BIT];
  // Redirect only matters once the vector has been loaded.
  assign running = (state_q == RUN) || (state_q == IMM);

  // Outputs toward IF/ID and the memory address, all combinational.
  always_comb begin
    imem_addr   = '0;
    instruction = 16'h0000;
    pc          = 32'h0;
    nextPC      = 32'h0;
    iamBubble   = 1'b1;
    flush       = 1'b0;
    case (state_q)
      VEC_HI: imem_addr = '0;
      VEC_LO: imem_addr = ADDR_W'(1);
      RUN: begin
        imem_addr   = pc_q[ADDR_W-1:0];
        instruction = imem_data;
        pc          = pc_q;
        nextPC      = has_imm ? pc_q + 32'd2 : pc_q + 32'd1;
        iamBubble   = 1'b0;
      end
      IMM: begin
        imem_addr   = pc_q[ADDR_W-1:0];
        instruction = imem_data;
        pc          = pc_q;
        nextPC      = pc_q + 32'd1;
        iamBubble   = 1'b1;
      end
      default: ;
    endcase
    // A redirect squashes whatever is being fetched this cycle.
    if (running && redirect) begin
      instruction = 16'h0000;
      iamBubble   = 1'b1;
      flush       = 1'b1;
    end
  end

  // Next-state: vector load, then redirect > stall > sequential advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      VEC_HI: begin
        pc_d    = {imem_data, pc_q[15:0]};
        state_d = VEC_LO;
      end
      VEC_LO: begin
        pc_d    = {pc_q[31:16], imem_data};
        state_d = RUN;
      end
      RUN, IMM: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd1;
          state_d = ((state_q == RUN) && has_imm) ? IMM : RUN;
        end
      end
      default: state_d = VEC_HI;
    endcase
  end

  // State registers with asynchronous reset back to the vector fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VEC_HI;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with fixed expectations, then a
// randomized run checked against a word-level model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] imem_data;
  logic [19:0] imem_addr;
  logic [15:0] instruction;
  logic [31:0] pc;
  logic [31:0] nextPC;
  logic        iamBubble;
  logic        flush;

  logic [15:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Small memory aliased over the full address space by the low 8 bits.
  always_comb imem_data = mem[imem_addr[7:0]];

  fetch_unit #(
    .ADDR_W (20),
    .IMM_BIT(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_data  (imem_data),
    .imem_addr  (imem_addr),
    .instruction(instruction),
    .pc         (pc),
    .nextPC     (nextPC),
    .iamBubble  (iamBubble),
    .flush      (flush)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Hold reset for two edges with the given vector, release just after an edge.
  task automatic start(input logic [15:0] lo);
    mem[0]      = 16'h0000;
    mem[1]      = lo;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_mem();
    rst = 1'b1; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h55;
    tick();
    #1;
    total++; if (imem_addr !== 20'h0) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, 20'h0); end
    total++; if (instruction !== 16'h0) begin bad++; $display("FAIL reset_instr: got %h want %h", instruction, 16'h0); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (nextPC !== 32'h0) begin bad++; $display("FAIL reset_next: got %h want %h", nextPC, 32'h0); end
    total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL reset_bubble: got %b want 1", iamBubble); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
    redirect = 1'b0;
  endtask

  task automatic test_vector;
    clear_mem();
    mem[16'h10] = 16'h0002;
    start(16'h0010);
    #1;
    total++; if (imem_addr !== 20'h0) begin bad++; $display("FAIL vec_addr0: got %h want %h", imem_addr, 20'h0); end
    total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL vec_bub0: got %b want 1", iamBubble); end
    tick();
    // Redirect during the vector load must be ignored.
    redirect = 1'b1; redirect_pc = 32'h99;
    #1;
    total++; if (imem_addr !== 20'h1) begin bad++; $display("FAIL vec_addr1: got %h want %h", imem_addr, 20'h1); end
    total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL vec_bub1: got %b want 1", iamBubble); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL vec_flush: got %b want 0", flush); end
    tick();
    redirect = 1'b0;
    #1;
    total++; if (imem_addr !== 20'h10) begin bad++; $display("FAIL vec_addr2: got %h want %h", imem_addr, 20'h10); end
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL vec_pc: got %h want %h", pc, 32'h10); end
    total++; if (iamBubble !== 1'b0) begin bad++; $display("FAIL vec_bub2: got %b want 0", iamBubble); end
  endtask

  task automatic test_sequential;
    logic [15:0] words [3];
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
    clear_mem();
    for (int i = 0; i < 3; i++) mem[16 + i] = words[i];
    start(16'h0010);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (pc !== 32'(16 + i)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(16 + i)); end
      total++; if (nextPC !== 32'(17 + i)) begin bad++; $display("FAIL seq_next%0d: got %h want %h", i, nextPC, 32'(17 + i)); end
      total++; if (iamBubble !== 1'b0) begin bad++; $display("FAIL seq_bub%0d: got %b want 0", i, iamBubble); end
      total++; if (instruction !== words[i]) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", i, instruction, words[i]); end
      tick();
    end
  endtask

  task automatic test_imm;
    clear_mem();
    mem[16'h10] = 16'h0001; mem[16'h11] = 16'hBEEF; mem[16'h12] = 16'h0000;
    start(16'h0010);
    tick();
    tick();
    #1;
    total++; if (instruction !== 16'h0001) begin bad++; $display("FAIL imm_instr1: got %h want %h", instruction, 16'h0001); end
    total++; if (nextPC !== 32'h12) begin bad++; $display("FAIL imm_next1: got %h want %h", nextPC, 32'h12); end
    total++; if (iamBubble !== 1'b0) begin bad++; $display("FAIL imm_bub1: got %b want 0", iamBubble); end
    tick();
    #1;
    total++; if (instruction !== 16'hBEEF) begin bad++; $display("FAIL imm_instr2: got %h want %h", instruction, 16'hBEEF); end
    total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL imm_bub2: got %b want 1", iamBubble); end
    total++; if (nextPC !== 32'h12) begin bad++; $display("FAIL imm_next2: got %h want %h", nextPC, 32'h12); end
    tick();
    #1;
    total++; if (pc !== 32'h12) begin bad++; $display("FAIL imm_pc3: got %h want %h", pc, 32'h12); end
    total++; if (iamBubble !== 1'b0) begin bad++; $display("FAIL imm_bub3: got %b want 0", iamBubble); end
  endtask

  task automatic test_stall;
    clear_mem();
    mem[16'h10] = 16'h0001; mem[16'h11] = 16'hBEEF; mem[16'h12] = 16'h0004;
    start(16'h0010);
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      stall = (i < 3);
      #1;
      total++; if (pc !== 32'h11) begin bad++; $display("FAIL stall_pc%0d: got %h want %h", i, pc, 32'h11); end
      total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL stall_bub%0d: got %b want 1", i, iamBubble); end
      total++; if (instruction !== 16'hBEEF) begin bad++; $display("FAIL stall_instr%0d: got %h want %h", i, instruction, 16'hBEEF); end
      tick();
    end
    stall = 1'b0;
    #1;
    total++; if (pc !== 32'h12) begin bad++; $display("FAIL stall_after_pc: got %h want %h", pc, 32'h12); end
    total++; if (iamBubble !== 1'b0) begin bad++; $display("FAIL stall_after_bub: got %b want 0", iamBubble); end
  endtask

  task automatic test_redirect;
    clear_mem();
    mem[16'h10] = 16'h0001; mem[16'h11] = 16'hBEEF; mem[16'h40] = 16'h0003;
    start(16'h0010);
    tick();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL redir_flush: got %b want 1", flush); end
    total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL redir_bub: got %b want 1", iamBubble); end
    total++; if (instruction !== 16'h0) begin bad++; $display("FAIL redir_instr: got %h want %h", instruction, 16'h0); end
    tick();
    redirect = 1'b0; stall = 1'b0;
    #1;
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL redir_pc: got %h want %h", pc, 32'h40); end
    total++; if (iamBubble !== 1'b0) begin bad++; $display("FAIL redir_bub2: got %b want 0", iamBubble); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL redir_flush2: got %b want 0", flush); end
    total++; if (instruction !== 16'h0003) begin bad++; $display("FAIL redir_instr2: got %h want %h", instruction, 16'h0003); end
    total++; if (nextPC !== 32'h42) begin bad++; $display("FAIL redir_next2: got %h want %h", nextPC, 32'h42); end
  endtask

  task automatic test_midrun_reset;
    clear_mem();
    for (int i = 0; i < 16; i++) mem[32 + i] = 16'(16'h1000 + 2 * i);
    start(16'h0020);
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    #1;
    total++; if (pc !== 32'h25) begin bad++; $display("FAIL mid_pc: got %h want %h", pc, 32'h25); end
    // Assert reset between edges; outputs must react without a clock.
    #2;
    rst = 1'b1;
    #1;
    total++; if (imem_addr !== 20'h0) begin bad++; $display("FAIL mid_rst_addr: got %h want %h", imem_addr, 20'h0); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_rst_pc: got %h want %h", pc, 32'h0); end
    total++; if (instruction !== 16'h0) begin bad++; $display("FAIL mid_rst_instr: got %h want %h", instruction, 16'h0); end
    total++; if (nextPC !== 32'h0) begin bad++; $display("FAIL mid_rst_next: got %h want %h", nextPC, 32'h0); end
    total++; if (iamBubble !== 1'b1) begin bad++; $display("FAIL mid_rst_bub: got %b want 1", iamBubble); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (imem_addr !== 20'h0) begin bad++; $display("FAIL mid_vec0: got %h want %h", imem_addr, 20'h0); end
    tick();
    #1;
    total++; if (imem_addr !== 20'h1) begin bad++; $display("FAIL mid_vec1: got %h want %h", imem_addr, 20'h1); end
    tick();
    #1;
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL mid_vec_pc: got %h want %h", pc, 32'h20); end
    total++; if (imem_addr !== 20'h20) begin bad++; $display("FAIL mid_vec_addr: got %h want %h", imem_addr, 20'h20); end
  endtask

  task automatic test_wrap;
    clear_mem();
    start(16'h0010);
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL wrap_flush: got %b want 1", flush); end
    tick();
    redirect = 1'b0;
    #1;
    total++; if (pc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pc: got %h want %h", pc, 32'hFFFF_FFFF); end
    total++; if (imem_addr !== 20'hFFFFF) begin bad++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 20'hFFFFF); end
    total++; if (nextPC !== 32'h0) begin bad++; $display("FAIL wrap_next: got %h want %h", nextPC, 32'h0); end
    tick();
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc2: got %h want %h", pc, 32'h0); end
    total++; if (imem_addr !== 20'h0) begin bad++; $display("FAIL wrap_addr2: got %h want %h", imem_addr, 20'h0); end
  endtask

  // Random memory, stalls and redirects; expected values come from a model that
  // tracks the next PC, how many vector words are still owed, and whether the
  // next word is an immediate.
  task automatic test_random;
    logic [31:0]  m_pc;
    int           m_vec;
    bit           m_imm;
    logic [19:0]  e_addr;
    logic [15:0]  w, e_instr;
    logic [31:0]  e_pc, e_next;
    logic         e_bub, e_flush;
    logic [101:0] got, want;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    start(16'($urandom));
    m_vec = 0; m_pc = 32'h0; m_imm = 1'b0;
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(9) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(255)))
                                             : 32'($urandom_range(255));
      e_addr = (m_vec == 0) ? 20'd0 : (m_vec == 1) ? 20'd1 : m_pc[19:0];
      w      = mem[e_addr[7:0]];
      e_pc   = (m_vec < 2) ? 32'h0 : m_pc;
      e_next = (m_vec < 2) ? 32'h0 : ((!m_imm && w[0]) ? m_pc + 32'd2 : m_pc + 32'd1);
      if (m_vec < 2) begin
        e_instr = 16'h0; e_bub = 1'b1; e_flush = 1'b0;
      end else if (redirect) begin
        e_instr = 16'h0; e_bub = 1'b1; e_flush = 1'b1;
      end else begin
        e_instr = w; e_bub = m_imm; e_flush = 1'b0;
      end
      #1;
      got  = {imem_addr, instruction, pc, nextPC, iamBubble, flush};
      want = {e_addr, e_instr, e_pc, e_next, e_bub, e_flush};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rand_c%0d: got addr=%h instr=%h pc=%h next=%h bub=%b flush=%b want %h %h %h %h %b %b",
                 c, imem_addr, instruction, pc, nextPC, iamBubble, flush,
                 e_addr, e_instr, e_pc, e_next, e_bub, e_flush);
      end
      tick();
      if (m_vec == 0) begin
        m_pc[31:16] = w; m_vec = 1;
      end else if (m_vec == 1) begin
        m_pc[15:0] = w; m_vec = 2; m_imm = 1'b0;
      end else if (redirect) begin
        m_pc = redirect_pc; m_imm = 1'b0;
      end else if (!stall) begin
        m_imm = !m_imm && w[0];
        m_pc  = m_pc + 32'd1;
      end
    end
    stall = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_vector();
    test_sequential();
    test_imm();
    test_stall();
    test_redirect();
    test_midrun_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
